// File: rtl/tpu_imem_responder.sv
// Instruction memory responder for the scalar unit's program counter.
// Loads a program by streaming beats, then serves fetches through a 2-entry FIFO.
module tpu_imem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               I_Ld_Req,
    input  logic               I_Ld_Valid,
    input  logic [INSTR_W-1:0] I_Ld_Data,
    input  logic               I_Ld_Last,
    output logic               O_Ld_Ready,
    output logic               O_Ld_Done,
    input  logic               I_IFetch,
    input  logic [ADDR_W-1:0]  I_Address,
    input  logic               I_Stall,
    output logic               O_Instr_Valid,
    output logic [INSTR_W-1:0] O_Instr,
    output logic [ADDR_W-1:0]  O_Instr_Addr,
    output logic               O_Instr_End,
    output logic               O_Busy,
    output logic               O_Err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  addr;
        logic               last;
    } ent_t;

    state_t             state;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] rd_data;
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W:0]    prog_len;
    logic               rd_vld;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_end;
    ent_t               head;
    ent_t               tail;
    ent_t               push_ent;
    logic [1:0]         count;
    logic               ld_done;
    logic               err;

    logic fetch_ok;
    logic beat;
    logic beat_final;
    logic pop;
    logic overflow;
    logic bad_fetch;

    assign fetch_ok   = (state == RUN) && I_IFetch && !I_Ld_Req;
    assign beat       = (state == LOAD) && I_Ld_Valid && !I_Ld_Req;
    assign beat_final = beat && (I_Ld_Last || wptr == ADDR_W'(DEPTH - 1));
    assign pop        = (count != 2'd0) && !I_Stall;
    assign overflow   = !I_Ld_Req && rd_vld && !pop && (count == 2'd2);
    assign bad_fetch  = !I_Ld_Req && I_IFetch && (state != RUN);

    // Past-end reads still touch the RAM; only the pushed word is masked.
    assign push_ent.data = rd_end ? '0 : rd_data;
    assign push_ent.addr = rd_addr;
    assign push_ent.last = rd_end;

    always_ff @(posedge clock) begin
        if (beat) mem[wptr] <= I_Ld_Data;
        if (fetch_ok) rd_data <= mem[I_Address];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wptr     <= '0;
            prog_len <= '0;
            ld_done  <= 1'b0;
            err      <= 1'b0;
            rd_vld   <= 1'b0;
            rd_addr  <= '0;
            rd_end   <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= 2'd0;
        end else begin
            ld_done <= beat_final;
            if (I_Ld_Req) begin
                state  <= LOAD;
                wptr   <= '0;
                err    <= 1'b0;
                rd_vld <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (overflow || bad_fetch) err <= 1'b1;
                if (beat) wptr <= wptr + 1'b1;
                if (beat_final) begin
                    prog_len <= {1'b0, wptr} + (ADDR_W + 1)'(1);
                    state    <= RUN;
                end
                rd_vld <= fetch_ok;
                if (fetch_ok) begin
                    rd_addr <= I_Address;
                    rd_end  <= {1'b0, I_Address} >= prog_len;
                end
                if (rd_vld) begin
                    if (pop) begin
                        if (count == 2'd2) begin
                            head <= tail;
                            tail <= push_ent;
                        end else begin
                            head <= push_ent;
                        end
                    end else if (count == 2'd0) begin
                        head  <= push_ent;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= push_ent;
                        count <= 2'd2;
                    end
                end else if (pop) begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
            end
        end
    end

    assign O_Ld_Ready    = (state == LOAD);
    assign O_Busy        = (state != RUN);
    assign O_Ld_Done     = ld_done;
    assign O_Err         = err;
    assign O_Instr_Valid = (count != 2'd0);
    assign O_Instr       = head.data;
    assign O_Instr_Addr  = head.addr;
    assign O_Instr_End   = head.last;

endmodule

// File: tb/tb_tpu_imem_responder.sv
// Directed bench for tpu_imem_responder: load, fetch, end-of-program,
// stall overflow, load preemption and asynchronous reset.
module tb_tpu_imem_responder;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 64;

    logic               clock = 1'b0;
    logic               reset;
    logic               I_Ld_Req;
    logic               I_Ld_Valid;
    logic [INSTR_W-1:0] I_Ld_Data;
    logic               I_Ld_Last;
    logic               O_Ld_Ready;
    logic               O_Ld_Done;
    logic               I_IFetch;
    logic [ADDR_W-1:0]  I_Address;
    logic               I_Stall;
    logic               O_Instr_Valid;
    logic [INSTR_W-1:0] O_Instr;
    logic [ADDR_W-1:0]  O_Instr_Addr;
    logic               O_Instr_End;
    logic               O_Busy;
    logic               O_Err;

    int n_vec  = 0;
    int n_fail = 0;

    tpu_imem_responder #(.DEPTH(1024), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clock(clock), .reset(reset),
        .I_Ld_Req(I_Ld_Req), .I_Ld_Valid(I_Ld_Valid),
        .I_Ld_Data(I_Ld_Data), .I_Ld_Last(I_Ld_Last),
        .O_Ld_Ready(O_Ld_Ready), .O_Ld_Done(O_Ld_Done),
        .I_IFetch(I_IFetch), .I_Address(I_Address), .I_Stall(I_Stall),
        .O_Instr_Valid(O_Instr_Valid), .O_Instr(O_Instr),
        .O_Instr_Addr(O_Instr_Addr), .O_Instr_End(O_Instr_End),
        .O_Busy(O_Busy), .O_Err(O_Err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        I_Ld_Req = 0; I_Ld_Valid = 0; I_Ld_Data = '0; I_Ld_Last = 0;
        I_IFetch = 0; I_Address = '0; I_Stall = 0;
        step();
        step();
        n_vec++;
        if ({O_Ld_Ready, O_Ld_Done, O_Instr_Valid, O_Instr_End, O_Busy, O_Err} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000010",
                     {O_Ld_Ready, O_Ld_Done, O_Instr_Valid, O_Instr_End, O_Busy, O_Err});
        end
        n_vec++;
        if (O_Instr !== 64'd0 || O_Instr_Addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h want 0/0", O_Instr, O_Instr_Addr);
        end
        #3 reset = 1'b1;
        step();
    endtask

    task automatic test_load();
        I_Ld_Req = 1;
        step();
        I_Ld_Req = 0;
        n_vec++;
        if (O_Ld_Ready !== 1'b1 || O_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_enter rdy=%b busy=%b want 1/1", O_Ld_Ready, O_Busy);
        end
        for (int i = 0; i < 4; i++) begin
            I_Ld_Valid = 1;
            I_Ld_Data  = 64'hA0 + 64'(i);
            I_Ld_Last  = (i == 3);
            step();
        end
        I_Ld_Valid = 0; I_Ld_Last = 0;
        n_vec++;
        if (O_Ld_Done !== 1'b1 || O_Busy !== 1'b0 || O_Ld_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done done=%b busy=%b rdy=%b want 1/0/0",
                     O_Ld_Done, O_Busy, O_Ld_Ready);
        end
        step();
        n_vec++;
        if (O_Ld_Done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done_pulse got %b want 0", O_Ld_Done);
        end
    endtask

    task automatic test_fetch_seq();
        for (int j = 0; j < 6; j++) begin
            I_IFetch  = (j < 4);
            I_Address = 10'(j);
            step();
            if (j >= 1 && j <= 4) begin
                n_vec++;
                if (O_Instr_Valid !== 1'b1 || O_Instr !== 64'hA0 + 64'(j - 1) ||
                    O_Instr_Addr !== 10'(j - 1) || O_Instr_End !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_seq[%0d] got v=%b %h @%0d e=%b want 1 %h @%0d 0",
                             j - 1, O_Instr_Valid, O_Instr, O_Instr_Addr, O_Instr_End,
                             64'hA0 + 64'(j - 1), j - 1);
                end
            end
        end
        I_IFetch = 0;
        n_vec++;
        if (O_Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_seq_drain valid=%b want 0", O_Instr_Valid);
        end
    endtask

    task automatic test_end_of_prog();
        I_IFetch = 1; I_Address = 10'd4;
        step();
        I_IFetch = 0;
        step();
        n_vec++;
        if (O_Instr_Valid !== 1'b1 || O_Instr !== 64'd0 || O_Instr_End !== 1'b1 ||
            O_Instr_Addr !== 10'd4 || O_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL end_of_prog got v=%b %h @%0d e=%b err=%b want 1 0 @4 1 0",
                     O_Instr_Valid, O_Instr, O_Instr_Addr, O_Instr_End, O_Err);
        end
        step();
    endtask

    task automatic test_stall_overflow();
        I_Stall = 1;
        I_IFetch = 1; I_Address = 10'd0;
        step();
        I_Address = 10'd1;
        step();
        n_vec++;
        if (O_Instr_Valid !== 1'b1 || O_Instr !== 64'hA0) begin
            n_fail++;
            $display("FAIL stall_head got v=%b %h want 1 a0", O_Instr_Valid, O_Instr);
        end
        I_Address = 10'd2;
        step();
        I_IFetch = 0;
        step();
        n_vec++;
        if (O_Err !== 1'b1 || O_Instr !== 64'hA0 || O_Instr_Addr !== 10'd0) begin
            n_fail++;
            $display("FAIL stall_overflow err=%b %h @%0d want 1 a0 @0",
                     O_Err, O_Instr, O_Instr_Addr);
        end
        I_Stall = 0;
        step();
        n_vec++;
        if (O_Instr_Valid !== 1'b1 || O_Instr !== 64'hA1 || O_Instr_Addr !== 10'd1) begin
            n_fail++;
            $display("FAIL stall_release got v=%b %h @%0d want 1 a1 @1",
                     O_Instr_Valid, O_Instr, O_Instr_Addr);
        end
        step();
        n_vec++;
        if (O_Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain valid=%b want 0", O_Instr_Valid);
        end
    endtask

    task automatic test_load_preempt();
        I_IFetch = 1; I_Address = 10'd0;
        step();
        I_Address = 10'd1;
        step();
        I_Ld_Req = 1; I_Address = 10'd2;
        step();
        I_Ld_Req = 0; I_IFetch = 0;
        n_vec++;
        if (O_Instr_Valid !== 1'b0 || O_Err !== 1'b0 || O_Ld_Ready !== 1'b1 || O_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt got v=%b err=%b rdy=%b busy=%b want 0 0 1 1",
                     O_Instr_Valid, O_Err, O_Ld_Ready, O_Busy);
        end
        step();
        n_vec++;
        if (O_Instr_Valid !== 1'b0 || O_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL preempt_inflight v=%b err=%b want 0 0", O_Instr_Valid, O_Err);
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 2; i++) begin
            I_Ld_Valid = 1; I_Ld_Data = 64'hC0 + 64'(i);
            step();
        end
        I_Ld_Valid = 0;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({O_Ld_Ready, O_Ld_Done, O_Instr_Valid, O_Instr_End, O_Busy, O_Err} !== 6'b000010 ||
            O_Instr !== 64'd0 || O_Instr_Addr !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset flags=%b %h @%0d want 000010 0 @0",
                     {O_Ld_Ready, O_Ld_Done, O_Instr_Valid, O_Instr_End, O_Busy, O_Err},
                     O_Instr, O_Instr_Addr);
        end
        #3 reset = 1'b1;
        step();
        I_IFetch = 1; I_Address = 10'd0;
        step();
        I_IFetch = 0;
        step();
        n_vec++;
        if (O_Err !== 1'b1 || O_Busy !== 1'b1 || O_Instr_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_fetch err=%b busy=%b v=%b want 1 1 0", O_Err, O_Busy, O_Instr_Valid);
        end
        I_Ld_Req = 1;
        step();
        I_Ld_Req = 0;
        I_Ld_Valid = 1; I_Ld_Data = 64'hB0; I_Ld_Last = 1;
        step();
        I_Ld_Valid = 0; I_Ld_Last = 0;
        n_vec++;
        if (O_Ld_Done !== 1'b1 || O_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL reload done=%b err=%b want 1 0", O_Ld_Done, O_Err);
        end
        I_IFetch = 1; I_Address = 10'd0;
        step();
        I_Address = 10'd1;
        step();
        I_IFetch = 0;
        n_vec++;
        if (O_Instr !== 64'hB0 || O_Instr_End !== 1'b0 || O_Instr_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_fetch got v=%b %h e=%b want 1 b0 0", O_Instr_Valid, O_Instr, O_Instr_End);
        end
        step();
        n_vec++;
        if (O_Instr !== 64'd0 || O_Instr_End !== 1'b1 || O_Instr_Addr !== 10'd1 || O_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_end got %h e=%b @%0d err=%b want 0 1 @1 0",
                     O_Instr, O_Instr_End, O_Instr_Addr, O_Err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch_seq();
        test_end_of_prog();
        test_stall_overflow();
        test_load_preempt();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
